rr_burst_arb: RTL and testbench
===============================

Name: rr_burst_arb

Overview:
- Round-robin arbiter that shares one burst-oriented resource (bus, memory port, FIFO write side) among N requesters.
- Unlike a per-cycle arbiter, it locks the grant for a whole transaction. It holds the grant until the granted requester's last beat is accepted, or until a maximum beat count forces release.
- The priority pointer then rotates past the winner.
- It sits between requester ports and a shared resource that signals per-beat acceptance.

Parameters:
- N, 16, number of requesters (N >= 2).
- MAX_BURST, 8, beats allowed per grant before forced release; 0 disables forced release.
- IDXW, $clog2(N), derived localparam, width of grant_idx.
- CNTW, $clog2(MAX_BURST+1), derived localparam, width of the beat counter (minimum 1).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; requester holds it high until granted and its burst completes.
- req_last  in  N  per-requester last-beat flag, sampled only for the granted index when beat=1.
- beat  in  1  resource accepted one beat from the granted requester this cycle.
- grant  out  N  registered one-hot grant; all zeros when idle.
- grant_valid  out  1  registered; equals |grant.
- grant_idx  out  IDXW  registered binary index of the granted requester; holds its last value when idle.
- forced_release  out  1  registered one-cycle pulse: the grant was ended by the MAX_BURST limit.

Behaviour:
- Reset (rst=1 at a clock edge, whether idle or mid-burst), next cycle:
  - grant=0, grant_valid=0, grant_idx=0, forced_release=0.
  - pointer={N{1'b1}}, beat_cnt=0, state=IDLE.
- States: IDLE, BUSY.
- Picker (combinational):
  - req_masked = req & pointer.
  - Winner is the lowest set index of req_masked if nonzero; otherwise the lowest set index of req.
- IDLE:
  - If |req, register the winner: grant=onehot(winner), grant_idx=winner, beat_cnt=0, state=BUSY.
  - Latency: req high at edge k -> grant visible after edge k (one cycle).
  - If no request, outputs stay idle and the pointer is unchanged.
- BUSY:
  - grant is held constant; req from other requesters is ignored.
  - beat=1 increments beat_cnt.
- Release conditions, evaluated in BUSY with beat=1:
  - req_last[grant_idx]=1 gives a normal release with forced_release=0. This takes priority when both conditions are true in the same cycle.
  - Otherwise, if MAX_BURST!=0 and beat_cnt==MAX_BURST-1, the release is forced with forced_release=1 for exactly one cycle.
- Abandon: req[grant_idx]=0 with beat=0 in BUSY is treated as a normal release.
- On release, at the next edge:
  - grant=0, grant_valid=0, state=IDLE, beat_cnt=0.
  - pointer = bits strictly above grant_idx set (e.g. idx 3, N=8 -> 8'b1111_0000).
  - For idx=N-1 the pointer becomes all zeros, so the next pick falls to the unmasked lowest index (wrap-around).
- Bubble: one guaranteed idle cycle between grants. A new grant appears no earlier than 2 cycles after the releasing beat.
- Ignored inputs:
  - beat while state=IDLE.
  - req_last of non-granted indices.
- forced_release is 0 in every cycle other than the one following a forced release.
- Fairness: a requester holding req continuously is granted within N-1 other grants.
- No internal storage of requests; requests are level-sensitive.

Decomposition:
- Package arb_pkg:
  - state encoding (IDLE=1'b0, BUSY=1'b1).
  - shared onehot-to-index function used by the picker and the bench.
- Sub-module rr_pick (combinational, parameter N):
  - inputs req and pointer.
  - outputs one-hot winner, winner index, any.
  - uses the masked/unmasked lowest-index priority chain.
- rr_burst_arb owns the state register, pointer, beat counter and output registers.

Test Plan:
- Reset then req=16'h0000 for 10 cycles -> grant=0, grant_valid=0, forced_release=0, pointer=16'hFFFF throughout.
- req=16'h0011 (both held), bursts of 3 beats with last on beat 3:
  - grants go idx0 -> idx4 -> idx0.
  - each grant stays constant for 3 beats.
  - exactly one idle cycle between grants.
- Single req[15]=1, 2-beat burst -> grant_idx=15; after release pointer=0. Then req=16'h8002 -> next grant idx1 (wrap), then idx15.
- MAX_BURST=8, granted requester never asserts last:
  - beat every cycle -> release after 8th beat.
  - forced_release=1 for one cycle, grant cleared.
- Last and limit coincide:
  - req_last=1 on 8th beat -> normal release, forced_release=0.
  - beat=1 while idle -> no counter change, no grant change.
- rst=1 mid-burst (idx5, 4 beats done) -> next cycle all outputs at reset values. With req[5] still high, regrant idx5 one cycle after rst deasserts, beat_cnt restarts at 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiter: state encoding and
// the one-hot to binary index helper used by the picker (and the bench).
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Widest one-hot vector the helper accepts; callers zero-extend.
    localparam int MAX_REQ = 64;

    // For a one-hot input, OR-ing the indices of all set bits yields the
    // index of the single set bit. Returns 0 for an all-zero input.
    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester at or above the
// priority pointer wins, falling back to the lowest requester overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 16,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    pointer,
    output logic [N-1:0]    winner,
    output logic [IDXW-1:0] winner_idx,
    output logic            any
);

    logic [N-1:0] masked;
    logic [N-1:0] sel;

    // Choose masked or unmasked candidates, then isolate the lowest set bit.
    always_comb begin
        masked     = req & pointer;
        sel        = (|masked) ? masked : req;
        winner     = sel & (~sel + N'(1));
        winner_idx = IDXW'(onehot_to_idx(MAX_REQ'(winner)));
        any        = |req;
    end

endmodule

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter that locks the grant for a whole burst. The grant is
// released on the granted requester's last beat, when it drops its request
// without a beat, or when the beat limit forces release. The priority
// pointer then rotates past the winner.
module rr_burst_arb
    import arb_pkg::*;
#(
    parameter  int N         = 16,
    parameter  int MAX_BURST = 8,
    localparam int IDXW      = (N > 1) ? $clog2(N) : 1,
    localparam int CNTW      = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_last,
    input  logic            beat,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            forced_release
);

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    pointer;
    logic [N-1:0]    pointer_next;
    logic [CNTW-1:0] beat_cnt;
    logic [CNTW-1:0] cnt_next;
    logic [N-1:0]    grant_next;
    logic [IDXW-1:0] idx_next;
    logic            forced_next;
    logic            release_now;
    logic            limit_hit;

    logic [N-1:0]    pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req),
        .pointer    (pointer),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // The limit is reached on the beat that brings the count to MAX_BURST.
    generate
        if (MAX_BURST != 0) begin : g_limit
            assign limit_hit = (beat_cnt == CNTW'(MAX_BURST - 1));
        end else begin : g_no_limit
            assign limit_hit = 1'b0;
        end
    endgenerate

    // Next-state, grant and pointer decisions.
    always_comb begin
        state_next   = state;
        pointer_next = pointer;
        cnt_next     = beat_cnt;
        grant_next   = grant;
        idx_next     = grant_idx;
        forced_next  = 1'b0;
        release_now  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_oh;
                    idx_next   = pick_idx;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (beat) begin
                    cnt_next = beat_cnt + CNTW'(1);
                    if (req_last[grant_idx]) begin
                        release_now = 1'b1;
                    end else if (limit_hit) begin
                        release_now = 1'b1;
                        forced_next = 1'b1;
                    end
                end else if (!req[grant_idx]) begin
                    release_now = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Pointer keeps only the bits strictly above the winner; for the top
        // index it becomes zero so the next pick wraps to the lowest request.
        if (release_now) begin
            grant_next   = '0;
            cnt_next     = '0;
            state_next   = IDLE;
            pointer_next = ~((grant << 1) - N'(1));
        end
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pointer        <= '1;
            beat_cnt       <= '0;
            grant          <= '0;
            grant_valid    <= 1'b0;
            grant_idx      <= '0;
            forced_release <= 1'b0;
        end else begin
            state          <= state_next;
            pointer        <= pointer_next;
            beat_cnt       <= cnt_next;
            grant          <= grant_next;
            grant_valid    <= |grant_next;
            grant_idx      <= idx_next;
            forced_release <= forced_next;
        end
    end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Bench for rr_burst_arb: directed bursts, a reference model that searches
// requesters round-robin from the previous winner, and literal spot checks.
module tb_rr_burst_arb;

    localparam int N         = 16;
    localparam int MAX_BURST = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_last;
    logic          beat;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [3:0]    grant_idx;
    logic          forced_release;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    rr_burst_arb #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_last       (req_last),
        .beat           (beat),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .grant_idx      (grant_idx),
        .forced_release (forced_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] m_grant;
    logic         m_busy;
    int           m_idx;
    int           m_last;   // previous winner, -1 means "no winner yet"
    int           m_beats;
    logic         m_forced;

    function automatic int model_pick(input logic [N-1:0] r, input int last);
        int w;
        w = -1;
        for (int i = last + 1; i < N; i++) if (w < 0 && r[i]) w = i;
        for (int i = 0; i < N; i++)        if (w < 0 && r[i]) w = i;
        return w;
    endfunction

    function automatic logic [N-1:0] model_ptr(input int last);
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = (i > last);
        return p;
    endfunction

    always @(posedge clk) begin
        m_forced <= 1'b0;
        if (rst) begin
            m_busy  <= 1'b0;
            m_grant <= '0;
            m_idx   <= 0;
            m_last  <= -1;
            m_beats <= 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_busy  <= 1'b1;
                m_idx   <= model_pick(req, m_last);
                m_grant <= N'(1) << model_pick(req, m_last);
                m_beats <= 0;
            end
        end else if ((beat && req_last[m_idx]) || (!beat && !req[m_idx]) ||
                     (beat && MAX_BURST != 0 && m_beats + 1 == MAX_BURST)) begin
            m_busy   <= 1'b0;
            m_grant  <= '0;
            m_last   <= m_idx;
            m_beats  <= 0;
            m_forced <= beat && !req_last[m_idx];
        end else if (beat) begin
            m_beats <= m_beats + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_grant", 32'(grant), 32'(m_grant));
            check("model_valid", 32'(grant_valid), 32'(m_busy));
            check("model_idx", 32'(grant_idx), 32'(m_idx));
            check("model_forced", 32'(forced_release), 32'(m_forced));
            check("model_pointer", 32'(dut.pointer), 32'(model_ptr(m_last)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive nbeats beats to the current grant; optionally flag last on the
    // final beat, and optionally toggle req_last of other requesters.
    task automatic do_burst(input int nbeats, input bit with_last, input bit noise, input int exp_idx);
        logic [N-1:0] oh;
        oh = N'(1) << exp_idx;
        for (int b = 1; b <= nbeats; b++) begin
            check("burst_idx", 32'(grant_idx), 32'(exp_idx));
            check("burst_valid", 32'(grant_valid), 32'd1);
            beat     = 1'b1;
            req_last = (with_last && b == nbeats) ? oh : (noise ? ~oh : '0);
            tick();
        end
        beat     = 1'b0;
        req_last = '0;
    endtask

    int exp_seq[3] = '{0, 4, 0};

    initial begin
        rst = 1'b1; req = '0; req_last = '0; beat = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_grant", 32'(grant), 32'h0);
            check("idle_valid", 32'(grant_valid), 32'h0);
            check("idle_forced", 32'(forced_release), 32'h0);
            check("idle_pointer", 32'(dut.pointer), 32'hFFFF);
        end

        // Two requesters alternate: 0 -> 4 -> 0
        req = 16'h0011;
        tick();
        for (int g = 0; g < 3; g++) begin
            check("rr_idx", 32'(arb_pkg::onehot_to_idx(64'(grant))), 32'(exp_seq[g]));
            do_burst(3, 1'b1, 1'b1, exp_seq[g]);
            check("rr_bubble", 32'(grant_valid), 32'h0);
            if (g == 2) req = '0;
            tick();
        end
        check("rr_end_pointer", 32'(dut.pointer), 32'hFFFE);

        // Top index then wrap-around
        req = 16'h8000;
        tick();
        check("wrap_idx15", 32'(grant_idx), 32'd15);
        do_burst(2, 1'b1, 1'b0, 15);
        check("wrap_pointer", 32'(dut.pointer), 32'h0);
        req = 16'h8002;
        tick();
        check("wrap_idx1", 32'(grant_idx), 32'd1);
        do_burst(2, 1'b1, 1'b0, 1);
        tick();
        check("wrap_back15", 32'(grant_idx), 32'd15);
        do_burst(2, 1'b1, 1'b0, 15);
        req = '0;
        tick();

        // Forced release after MAX_BURST beats with no last
        req = 16'h0004;
        tick();
        do_burst(8, 1'b0, 1'b1, 2);
        check("forced_pulse", 32'(forced_release), 32'd1);
        check("forced_cleared", 32'(grant), 32'h0);
        req = '0;
        tick();
        check("forced_one_cycle", 32'(forced_release), 32'd0);
        check("forced_pointer", 32'(dut.pointer), 32'hFFF8);

        // Last coincides with limit: normal release
        req = 16'h0008;
        tick();
        do_burst(8, 1'b1, 1'b0, 3);
        check("coincide_forced", 32'(forced_release), 32'd0);
        check("coincide_valid", 32'(grant_valid), 32'd0);
        req  = '0;
        beat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_beat_valid", 32'(grant_valid), 32'd0);
            check("idle_beat_cnt", 32'(dut.beat_cnt), 32'd0);
        end
        beat = 1'b0;

        // Abandon: request dropped without a beat
        req = 16'h0040;
        tick();
        check("abandon_idx", 32'(grant_idx), 32'd6);
        req = '0;
        tick();
        check("abandon_valid", 32'(grant_valid), 32'd0);
        check("abandon_forced", 32'(forced_release), 32'd0);

        // Reset in the middle of a burst
        req = 16'h0020;
        tick();
        do_burst(4, 1'b0, 1'b0, 5);
        check("mid_cnt", 32'(dut.beat_cnt), 32'd4);
        rst  = 1'b1;
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_forced", 32'(forced_release), 32'h0);
        check("rst_pointer", 32'(dut.pointer), 32'hFFFF);
        rst = 1'b0;
        tick();
        check("regrant_idx", 32'(grant_idx), 32'd5);
        check("regrant_valid", 32'(grant_valid), 32'd1);
        check("regrant_cnt", 32'(dut.beat_cnt), 32'd0);
        do_burst(2, 1'b1, 1'b0, 5);
        req = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
